ahb_mux_nm1s: RTL and testbench

Parametrised N-master to 1-slave AHB-Lite bus multiplexor with round-robin or fixed-priority arbitration, optional bus parking, and registered data-phase tracking. It sits between NM AHB-Lite masters (CPU, DMA engines, debug port) and a single slave-side fabric port. It is the N-port successor of the two-master mux: HWDATA and HRESP follow the data-phase owner, and losing requesters are stalled through their per-master HREADY.

---
 rtl/ahb_mux_nm1s.sv | 114 +++++++++++
 tb/tb_ahb_mux_nm1s.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_mux_nm1s.sv
// N-master to 1-slave AHB-Lite multiplexor with round-robin or fixed-priority
// arbitration, optional bus parking and registered data-phase ownership.
module ahb_mux_nm1s #(
  parameter int NM       = 4,
  parameter int SZ       = 64,
  parameter int ARB_MODE = 0,
  parameter int PARK     = 1,
  parameter int MW       = $clog2(NM)
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic [NM*32-1:0] HADDR_M,
  input  logic [NM*2-1:0]  HTRANS_M,
  input  logic [NM-1:0]    HWRITE_M,
  input  logic [NM*3-1:0]  HSIZE_M,
  input  logic [NM*SZ-1:0] HWDATA_M,
  output logic [NM-1:0]    HREADY_M,
  output logic [NM-1:0]    HRESP_M,
  output logic [SZ-1:0]    HRDATA_M,
  input  logic             HREADY,
  input  logic             HRESP,
  input  logic [SZ-1:0]    HRDATA,
  output logic [31:0]      HADDR,
  output logic [1:0]       HTRANS,
  output logic             HWRITE,
  output logic [2:0]       HSIZE,
  output logic [SZ-1:0]    HWDATA,
  output logic [MW-1:0]    HMASTER,
  output logic [NM-1:0]    HGRANT
);

  logic [MW-1:0] gnt, dph, pick;
  logic          gvalid, dvalid;
  logic [NM-1:0] req;
  logic          owner_req;

  logic [31:0]   addr_a  [NM];
  logic [1:0]    trans_a [NM];
  logic [2:0]    size_a  [NM];
  logic [SZ-1:0] wdata_a [NM];

  always_comb begin
    for (int i = 0; i < NM; i++) begin
      addr_a[i]  = HADDR_M[i*32 +: 32];
      trans_a[i] = HTRANS_M[i*2 +: 2];
      size_a[i]  = HSIZE_M[i*3 +: 3];
      wdata_a[i] = HWDATA_M[i*SZ +: SZ];
      req[i]     = HTRANS_M[i*2+1];
    end
  end

  assign owner_req = req[gnt];

  // Loops run in reverse so the last hit is the highest-priority candidate.
  always_comb begin
    logic [MW-1:0] idx;
    pick = gnt;
    idx  = '0;
    if (ARB_MODE == 0) begin
      for (int k = NM; k >= 1; k--) begin
        idx = MW'((int'(gnt) + k) % NM);
        if (req[idx]) pick = idx;
      end
    end else begin
      for (int i = NM - 1; i >= 0; i--) begin
        idx = MW'(i);
        if (req[idx]) pick = idx;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      gnt    <= '0;
      gvalid <= (PARK != 0);
      dph    <= '0;
      dvalid <= 1'b0;
    end else if (HREADY) begin
      if (!gvalid || !owner_req) begin
        if (|req) begin
          gnt    <= pick;
          gvalid <= 1'b1;
        end else begin
          gvalid <= (PARK != 0);
        end
      end
      dvalid <= gvalid & owner_req;
      dph    <= gnt;
    end
  end

  always_comb begin
    HADDR    = gvalid ? addr_a[gnt]  : '0;
    HTRANS   = gvalid ? trans_a[gnt] : '0;
    HWRITE   = gvalid ? HWRITE_M[gnt] : 1'b0;
    HSIZE    = gvalid ? size_a[gnt]  : '0;
    HWDATA   = dvalid ? wdata_a[dph] : '0;
    HRDATA_M = HRDATA;
    HMASTER  = gnt;
    HGRANT   = '0;
    HRESP_M  = '0;
    HREADY_M = '0;
    for (int i = 0; i < NM; i++) begin
      HGRANT[i]  = gvalid && (MW'(i) == gnt);
      HRESP_M[i] = dvalid && (MW'(i) == dph) && HRESP;
      // Owners see the slave; idle masters see ready; waiting requesters stall.
      if ((gvalid && (MW'(i) == gnt)) || (dvalid && (MW'(i) == dph)))
        HREADY_M[i] = HREADY;
      else
        HREADY_M[i] = !req[i];
    end
  end

endmodule

// File: tb/tb_ahb_mux_nm1s.sv
// Directed bench: instance a is round-robin with parking, instance b is
// fixed priority without parking; the idle instance is held in reset.
module tb_ahb_mux_nm1s;
  localparam int NM = 4;
  localparam int SZ = 32;
  localparam logic [1:0] IDLE = 2'b00, NSEQ = 2'b10, SEQ = 2'b11;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  logic [NM*32-1:0] haddr_m;
  logic [NM*2-1:0]  htrans_m;
  logic [NM-1:0]    hwrite_m;
  logic [NM*3-1:0]  hsize_m;
  logic [NM*SZ-1:0] hwdata_m;
  logic             sl_ready, sl_resp;
  logic [SZ-1:0]    sl_rdata;

  logic [1:0]  m_trans [NM];
  logic [31:0] m_addr  [NM];
  logic        m_write [NM];
  logic [31:0] m_wdata [NM];

  logic [NM-1:0] a_hready_m, a_hresp_m, b_hready_m, b_hresp_m;
  logic [SZ-1:0] a_hrdata_m, b_hrdata_m, a_hwdata, b_hwdata;
  logic [31:0]   a_haddr, b_haddr;
  logic [1:0]    a_htrans, b_htrans, a_hmaster, b_hmaster;
  logic          a_hwrite, b_hwrite;
  logic [2:0]    a_hsize, b_hsize;
  logic [NM-1:0] a_hgrant, b_hgrant;

  int checks = 0;
  int errors = 0;
  int acc [NM];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NM; i++) begin
      haddr_m[i*32 +: 32]  = m_addr[i];
      htrans_m[i*2 +: 2]   = m_trans[i];
      hwrite_m[i]          = m_write[i];
      hsize_m[i*3 +: 3]    = 3'b010;
      hwdata_m[i*SZ +: SZ] = m_wdata[i];
    end
  end

  ahb_mux_nm1s #(.NM(NM), .SZ(SZ), .ARB_MODE(0), .PARK(1)) dut_a (
    .HCLK(clk), .HRESET(rst_a), .HADDR_M(haddr_m), .HTRANS_M(htrans_m),
    .HWRITE_M(hwrite_m), .HSIZE_M(hsize_m), .HWDATA_M(hwdata_m),
    .HREADY_M(a_hready_m), .HRESP_M(a_hresp_m), .HRDATA_M(a_hrdata_m),
    .HREADY(sl_ready), .HRESP(sl_resp), .HRDATA(sl_rdata),
    .HADDR(a_haddr), .HTRANS(a_htrans), .HWRITE(a_hwrite), .HSIZE(a_hsize),
    .HWDATA(a_hwdata), .HMASTER(a_hmaster), .HGRANT(a_hgrant));

  ahb_mux_nm1s #(.NM(NM), .SZ(SZ), .ARB_MODE(1), .PARK(0)) dut_b (
    .HCLK(clk), .HRESET(rst_b), .HADDR_M(haddr_m), .HTRANS_M(htrans_m),
    .HWRITE_M(hwrite_m), .HSIZE_M(hsize_m), .HWDATA_M(hwdata_m),
    .HREADY_M(b_hready_m), .HRESP_M(b_hresp_m), .HRDATA_M(b_hrdata_m),
    .HREADY(sl_ready), .HRESP(sl_resp), .HRDATA(sl_rdata),
    .HADDR(b_haddr), .HTRANS(b_htrans), .HWRITE(b_hwrite), .HSIZE(b_hsize),
    .HWDATA(b_hwdata), .HMASTER(b_hmaster), .HGRANT(b_hgrant));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int m, input logic [1:0] t, input logic [31:0] a,
                       input logic w, input logic [31:0] d);
    m_trans[m] = t;
    m_addr[m]  = a;
    m_write[m] = w;
    m_wdata[m] = d;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Accepted address phases of instance a, per master.
  always @(posedge clk) begin
    if (rst_a) begin
      for (int i = 0; i < NM; i++) acc[i] = 0;
    end else if (sl_ready && a_htrans[1]) begin
      acc[a_hmaster] = acc[a_hmaster] + 1;
    end
  end

  // A data-phase owner must also be the address-phase owner.
  always @(negedge clk) begin
    if (!rst_a && dut_a.dvalid) begin
      checks++;
      assert (dut_a.dph === dut_a.gnt) else begin
        errors++;
        $error("FAIL inv_a observed=0x%0h expected=0x%0h", dut_a.dph, dut_a.gnt);
      end
    end
    if (!rst_b && dut_b.dvalid) begin
      checks++;
      assert (dut_b.dph === dut_b.gnt) else begin
        errors++;
        $error("FAIL inv_b observed=0x%0h expected=0x%0h", dut_b.dph, dut_b.gnt);
      end
    end
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    sl_ready = 1'b1; sl_resp = 1'b0; sl_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < NM; i++) drive(i, IDLE, 32'h0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    #1;
    chk("a_rst_hgrant", a_hgrant, 4'b0001);
    chk("a_rst_htrans", a_htrans, 2'b00);
    chk("a_rst_hwdata", a_hwdata, 32'h0);
    chk("a_rst_hmaster", a_hmaster, 2'd0);
    chk("a_rst_hresp_m", a_hresp_m, 4'b0000);
    chk("a_rst_hready_m", a_hready_m, 4'b1111);
    chk("b_rst_hgrant", b_hgrant, 4'b0000);
    chk("b_rst_htrans", b_htrans, 2'b00);

    // Parked owner: zero-latency pass-through
    rst_a = 1'b0;
    drive(0, NSEQ, 32'h1000, 1'b1, 32'h1111_1111);
    #1;
    chk("a_park_haddr", a_haddr, 32'h1000);
    chk("a_park_htrans", a_htrans, NSEQ);
    chk("a_park_hwrite", a_hwrite, 1'b1);
    chk("a_park_hsize", a_hsize, 3'b010);
    chk("a_park_hready_m", a_hready_m, 4'b1111);
    chk("a_hrdata_m", a_hrdata_m, 32'hCAFE_F00D);
    nxt(); drive(0, IDLE, 32'h1000, 1'b0, 32'h1111_1111); #1;
    chk("a_m0_hwdata", a_hwdata, 32'h1111_1111);
    chk("a_m0_idle_htrans", a_htrans, IDLE);

    // M1 from idle bus: one-cycle latency, makes last grant = 1
    nxt(); drive(1, NSEQ, 32'h2000, 1'b0, 32'h0); #1;
    chk("a_m1_req_hready_m", a_hready_m, 4'b1101);
    chk("a_m1_req_hmaster", a_hmaster, 2'd0);
    chk("a_m1_req_hwdata", a_hwdata, 32'h0);
    nxt(); #1;
    chk("a_m1_haddr", a_haddr, 32'h2000);
    chk("a_m1_hmaster", a_hmaster, 2'd1);
    chk("a_m1_hgrant", a_hgrant, 4'b0010);
    chk("a_m1_hready_m", a_hready_m, 4'b1111);

    // M1 data phase errors while M0, M2, M3 request together
    nxt();
    drive(1, IDLE, 32'h2000, 1'b0, 32'h0);
    drive(0, NSEQ, 32'h3000, 1'b0, 32'h0);
    drive(2, NSEQ, 32'h3200, 1'b0, 32'h0);
    drive(3, NSEQ, 32'h3300, 1'b0, 32'h0);
    sl_resp = 1'b1;
    #1;
    chk("a_err_hresp_m", a_hresp_m, 4'b0010);
    chk("a_rr_wait_hready_m", a_hready_m, 4'b0010);
    chk("a_rr_bubble_htrans", a_htrans, IDLE);
    nxt(); sl_resp = 1'b0; #1;
    chk("a_rr1_hmaster", a_hmaster, 2'd2);
    chk("a_rr1_haddr", a_haddr, 32'h3200);
    chk("a_rr1_hready_m", a_hready_m, 4'b0110);
    chk("a_rr1_hresp_m", a_hresp_m, 4'b0000);
    nxt(); drive(2, IDLE, 32'h3200, 1'b0, 32'h0); #1;
    chk("a_rr1_idle_htrans", a_htrans, IDLE);
    chk("a_rr1_idle_hready_m", a_hready_m, 4'b0110);
    nxt(); #1;
    chk("a_rr2_hmaster", a_hmaster, 2'd3);
    chk("a_rr2_haddr", a_haddr, 32'h3300);
    chk("a_rr2_hready_m", a_hready_m, 4'b1110);
    nxt(); drive(3, IDLE, 32'h3300, 1'b0, 32'h0); #1;
    chk("a_rr2_idle_htrans", a_htrans, IDLE);
    chk("a_rr2_idle_hready_m", a_hready_m, 4'b1110);
    nxt(); #1;
    chk("a_rr3_hmaster", a_hmaster, 2'd0);
    chk("a_rr3_haddr", a_haddr, 32'h3000);
    chk("a_rr3_hready_m", a_hready_m, 4'b1111);
    nxt(); drive(0, IDLE, 32'h3000, 1'b0, 32'h0); #1;
    chk("a_acc_m0", acc[0], 2);
    chk("a_acc_m1", acc[1], 1);
    chk("a_acc_m2", acc[2], 1);
    chk("a_acc_m3", acc[3], 1);

    // M2 write with two slave wait states
    nxt(); drive(2, NSEQ, 32'h20, 1'b1, 32'hDEAD_BEEF); #1;
    chk("a_ws_req_hready_m", a_hready_m, 4'b1011);
    chk("a_ws_req_hmaster", a_hmaster, 2'd0);
    nxt(); #1;
    chk("a_ws_hmaster", a_hmaster, 2'd2);
    chk("a_ws_haddr", a_haddr, 32'h20);
    chk("a_ws_hwrite", a_hwrite, 1'b1);
    chk("a_ws_hready_m", a_hready_m, 4'b1111);
    nxt(); drive(2, IDLE, 32'h20, 1'b0, 32'hDEAD_BEEF); sl_ready = 1'b0; #1;
    chk("a_ws1_hwdata", a_hwdata, 32'hDEAD_BEEF);
    chk("a_ws1_haddr", a_haddr, 32'h20);
    chk("a_ws1_hready_m", a_hready_m, 4'b1011);
    nxt(); #1;
    chk("a_ws2_hwdata", a_hwdata, 32'hDEAD_BEEF);
    chk("a_ws2_haddr", a_haddr, 32'h20);
    chk("a_ws2_hready_m", a_hready_m, 4'b1011);
    chk("a_ws2_hmaster", a_hmaster, 2'd2);
    nxt(); sl_ready = 1'b1; #1;
    chk("a_ws3_hwdata", a_hwdata, 32'hDEAD_BEEF);
    chk("a_ws3_hready_m", a_hready_m, 4'b1111);
    nxt(); #1;
    chk("a_ws_done_hwdata", a_hwdata, 32'h0);
    chk("a_ws_park_hmaster", a_hmaster, 2'd2);
    chk("a_ws_park_hgrant", a_hgrant, 4'b0100);

    // Instance b: fixed priority, no parking
    rst_a = 1'b1;
    rst_b = 1'b0;
    drive(1, NSEQ, 32'h100, 1'b0, 32'h1111_1111);
    drive(3, NSEQ, 32'h300, 1'b1, 32'h3333_3333);
    #1;
    chk("b_idle_hgrant", b_hgrant, 4'b0000);
    chk("b_idle_htrans", b_htrans, IDLE);
    chk("b_idle_haddr", b_haddr, 32'h0);
    chk("b_fp_req_hready_m", b_hready_m, 4'b0101);
    nxt(); #1;
    chk("b_fp_hmaster", b_hmaster, 2'd1);
    chk("b_fp_hgrant", b_hgrant, 4'b0010);
    chk("b_fp_haddr", b_haddr, 32'h100);
    chk("b_fp_hready_m", b_hready_m, 4'b0111);
    nxt(); drive(1, SEQ, 32'h104, 1'b0, 32'h1111_1111); #1;
    chk("b_fp_seq_haddr", b_haddr, 32'h104);
    chk("b_fp_seq_htrans", b_htrans, SEQ);
    chk("b_fp_seq_hready_m", b_hready_m, 4'b0111);
    nxt(); drive(1, IDLE, 32'h104, 1'b0, 32'h1111_1111); #1;
    chk("b_fp_idle_htrans", b_htrans, IDLE);
    chk("b_fp_idle_hmaster", b_hmaster, 2'd1);
    chk("b_fp_idle_hready_m", b_hready_m, 4'b0111);
    nxt(); #1;
    chk("b_m3_hmaster", b_hmaster, 2'd3);
    chk("b_m3_haddr", b_haddr, 32'h300);
    chk("b_m3_hwrite", b_hwrite, 1'b1);
    chk("b_m3_hready_m", b_hready_m, 4'b1111);
    nxt(); drive(3, IDLE, 32'h300, 1'b0, 32'h3333_3333); #1;
    chk("b_m3_hwdata", b_hwdata, 32'h3333_3333);

    // Burst lock: M0 INCR4 while M1 waits
    nxt();
    drive(0, NSEQ, 32'h400, 1'b1, 32'h0);
    drive(1, NSEQ, 32'h500, 1'b0, 32'h0);
    #1;
    chk("b_rel_hgrant", b_hgrant, 4'b0000);
    chk("b_rel_htrans", b_htrans, IDLE);
    chk("b_bl_req_hready_m", b_hready_m, 4'b1100);
    nxt(); #1;
    chk("b_bl0_hmaster", b_hmaster, 2'd0);
    chk("b_bl0_haddr", b_haddr, 32'h400);
    chk("b_bl0_hready_m", b_hready_m, 4'b1101);
    for (int b = 1; b < 4; b++) begin
      nxt(); drive(0, SEQ, 32'h400 + 32'(4*b), 1'b1, 32'h0); #1;
      chk("b_bl_haddr", b_haddr, 32'h400 + 32'(4*b));
      chk("b_bl_hmaster", b_hmaster, 2'd0);
      chk("b_bl_hready_m", b_hready_m, 4'b1101);
    end
    nxt(); drive(0, IDLE, 32'h40C, 1'b0, 32'h0); #1;
    chk("b_bl_end_htrans", b_htrans, IDLE);
    chk("b_bl_end_hmaster", b_hmaster, 2'd0);
    chk("b_bl_end_hready_m", b_hready_m, 4'b1101);
    nxt(); #1;
    chk("b_m1_hmaster", b_hmaster, 2'd1);
    chk("b_m1_haddr", b_haddr, 32'h500);
    chk("b_m1_hready_m", b_hready_m, 4'b1111);
    nxt(); drive(1, IDLE, 32'h500, 1'b0, 32'h0); #1;
    chk("b_m1_idle_hgrant", b_hgrant, 4'b0010);
    nxt(); #1;
    chk("b_end_hgrant", b_hgrant, 4'b0000);
    chk("b_end_htrans", b_htrans, IDLE);
    chk("b_end_haddr", b_haddr, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
